// File: rtl/ram_bist_master.sv
// Single-port RAM BIST initiator: writes an incrementing pattern over an address
// window, reads it back and compares. Optional macro RAM_BIST_STOP_ON_ERR_EN aborts on first mismatch.
module ram_bist_master #(
  parameter int          AW     = 4,
  parameter int          DW     = 4,
  parameter logic [31:0] MASK   = 32'd7,
  parameter int          RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic [AW:0]   LEN,
  input  logic [DW-1:0] SEED,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          EN,
  output logic          WR,
  input  logic [DW-1:0] Q,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic [AW:0]   ERR_CNT,
  output logic [AW-1:0] FAIL_ADDR
);

  localparam logic [DW-1:0] LP_MASK = MASK[DW-1:0];

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t                     r_st;
  logic [AW-1:0]              r_a, r_base, r_fail_addr;
  logic [DW-1:0]              r_d, r_seed, r_exp;
  logic [AW:0]                r_len, r_idx, r_err;
  logic                       r_en, r_wr, r_busy, r_done, r_fail;
  logic [RD_LAT-1:0]          r_vld_pipe;
  logic [RD_LAT-1:0][AW-1:0]  r_pa;
  logic [RD_LAT-1:0][DW-1:0]  r_pe;

  logic w_cmp, w_miss;

  // Compares only count while a pass is reading or draining; stale entries after an abort are ignored.
  assign w_cmp  = r_vld_pipe[RD_LAT-1] && (r_st == S_READ || r_st == S_DRAIN);
  assign w_miss = w_cmp && (|((Q ^ r_pe[RD_LAT-1]) & LP_MASK));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_st        <= S_IDLE;
      r_a         <= '0;
      r_d         <= '0;
      r_en        <= 1'b0;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_base      <= '0;
      r_seed      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_exp       <= '0;
      r_vld_pipe  <= '0;
      r_pa        <= '0;
      r_pe        <= '0;
    end else begin
      r_done        <= 1'b0;
      r_vld_pipe[0] <= r_en & ~r_wr;
      r_pa[0]       <= r_a;
      r_pe[0]       <= r_exp;
      for (int j = 1; j < RD_LAT; j++) begin
        r_vld_pipe[j] <= r_vld_pipe[j-1];
        r_pa[j]       <= r_pa[j-1];
        r_pe[j]       <= r_pe[j-1];
      end

      if (w_miss) begin
        r_fail <= 1'b1;
        if (r_err != '1) r_err <= r_err + 1'b1;
        if (!r_fail) r_fail_addr <= r_pa[RD_LAT-1];
      end

      case (r_st)
        S_IDLE: if (START) begin
          r_base      <= BASE;
          r_len       <= LEN;
          r_seed      <= SEED;
          r_fail      <= 1'b0;
          r_err       <= '0;
          r_fail_addr <= '0;
          r_busy      <= 1'b1;
          r_vld_pipe  <= '0;
          if (LEN == '0) begin
            r_st <= S_FIN;
          end else begin
            r_st  <= S_WRITE;
            r_en  <= 1'b1;
            r_wr  <= 1'b1;
            r_a   <= BASE;
            r_d   <= SEED;
            r_idx <= '0;
          end
        end
        S_WRITE: if (r_idx == r_len - 1'b1) begin
          r_st  <= S_READ;
          r_wr  <= 1'b0;
          r_a   <= r_base;
          r_exp <= r_seed;
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
          r_a   <= r_a + 1'b1;
          r_d   <= r_d + 1'b1;
        end
        S_READ: if (r_idx == r_len - 1'b1) begin
          r_st  <= S_DRAIN;
          r_en  <= 1'b0;
          r_idx <= (AW+1)'(RD_LAT - 1);
        end else begin
          r_idx <= r_idx + 1'b1;
          r_a   <= r_a + 1'b1;
          r_exp <= r_exp + 1'b1;
        end
        S_DRAIN: if (r_idx == '0) r_st <= S_FIN;
                 else             r_idx <= r_idx - 1'b1;
        S_FIN: begin
          r_st   <= S_IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: r_st <= S_IDLE;
      endcase

`ifdef RAM_BIST_STOP_ON_ERR_EN
      if (w_miss) begin
        r_st <= S_FIN;
        r_en <= 1'b0;
        r_wr <= 1'b0;
      end
`endif
    end
  end

  assign A         = r_a;
  assign D         = r_d;
  assign EN        = r_en;
  assign WR        = r_wr;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign FAIL      = r_fail;
  assign ERR_CNT   = r_err;
  assign FAIL_ADDR = r_fail_addr;

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench for ram_bist_master with a behavioural RAM carrying stuck-at-0 read faults.
module tb_ram_bist_master;
  localparam int AW = 4, DW = 4, RD_LAT = 1;

  logic          CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic [AW-1:0] BASE = '0;
  logic [AW:0]   LEN = '0;
  logic [DW-1:0] SEED = '0;
  logic [AW-1:0] A, FAIL_ADDR;
  logic [DW-1:0] D;
  logic [DW-1:0] Q = '0;
  logic          EN, WR, BUSY, DONE, FAIL;
  logic [AW:0]   ERR_CNT;

  int total = 0, bad = 0;
  always #5 CLK = ~CLK;

  ram_bist_master #(.AW(AW), .DW(DW), .MASK(32'd7), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN), .SEED(SEED),
    .A(A), .D(D), .EN(EN), .WR(WR), .Q(Q), .BUSY(BUSY), .DONE(DONE),
    .FAIL(FAIL), .ERR_CNT(ERR_CNT), .FAIL_ADDR(FAIL_ADDR));

  logic [DW-1:0] mem [2**AW];
  int            f_bit = 0;
  logic [AW-1:0] f_a0 = '0, f_a1 = '0;
  logic          f_on0 = 1'b0, f_on1 = 1'b0;

  logic [AW-1:0] log_a  [256];
  logic [DW-1:0] log_d  [256];
  logic          log_wr [256];
  int            nacc = 0;

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = v;
    if ((f_on0 && a == f_a0) || (f_on1 && a == f_a1)) r[f_bit] = 1'b0;
    return r;
  endfunction

  always @(posedge CLK) begin
    if (EN) begin
      if (WR) mem[A] <= D;
      else    Q <= rd_fault(mem[A], A);
      log_a[nacc]  <= A;
      log_d[nacc]  <= D;
      log_wr[nacc] <= WR;
      nacc         <= nacc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic busy0, en0;

  // Raises START in the current (IDLE) cycle; n = edges after accept until DONE is seen.
  task automatic run(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] s,
                     input int rep, output int n, output int s0);
    s0 = nacc; n = -1;
    BASE = b; LEN = l; SEED = s; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    busy0 = BUSY; en0 = EN;
    for (int c = 0; c < 100; c++) begin
      if (DONE) begin n = c; break; end
      if (c == rep) begin START = 1'b1; BASE = '0; SEED = '0; LEN = 3; end
      else START = 1'b0;
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  int n, s0, hit14;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_en", 32'(EN), 0);
    chk("rst_wr", 32'(WR), 0);
    chk("rst_a", 32'(A), 0);
    chk("rst_d", 32'(D), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_fail", 32'(FAIL), 0);
    chk("rst_err", 32'(ERR_CNT), 0);
    chk("rst_faddr", 32'(FAIL_ADDR), 0);
    RST = 1'b0;
    @(negedge CLK);

    // good RAM, window wraps past 15
    run(4'd10, 5'd10, 4'd2, -1, n, s0);
    chk("good_lat", 32'(n), 22);
    chk("good_busy0", 32'(busy0), 1);
    chk("good_en0", 32'(en0), 1);
    chk("good_busy_at_done", 32'(BUSY), 0);
    chk("good_fail", 32'(FAIL), 0);
    chk("good_err", 32'(ERR_CNT), 0);
    chk("good_nacc", 32'(nacc - s0), 20);
    for (int i = 0; i < 10; i++) begin
      chk("good_wa", 32'(log_a[s0+i]), (10 + i) % 16);
      chk("good_wd", 32'(log_d[s0+i]), (2 + i) % 16);
      chk("good_wwr", 32'(log_wr[s0+i]), 1);
      chk("good_ra", 32'(log_a[s0+10+i]), (10 + i) % 16);
      chk("good_rwr", 32'(log_wr[s0+10+i]), 0);
    end

    // full depth, data wraps 15 -> 0; started in the IDLE cycle right after DONE
    run(4'd0, 5'd16, 4'd15, -1, n, s0);
    chk("full_lat", 32'(n), 34);
    chk("full_fail", 32'(FAIL), 0);
    chk("full_nacc", 32'(nacc - s0), 32);
    for (int i = 0; i < 16; i++) chk("full_wd", 32'(log_d[s0+i]), (15 + i) % 16);

    // bit 1 stuck-at-0 at address 3, expected 11 there
    f_bit = 1; f_a0 = 4'd3; f_on0 = 1'b1;
    run(4'd0, 5'd8, 4'd8, -1, n, s0);
    chk("f1_lat", 32'(n), 18);
    chk("f1_fail", 32'(FAIL), 1);
    chk("f1_err", 32'(ERR_CNT), 1);
    chk("f1_faddr", 32'(FAIL_ADDR), 3);

    // bit 3 is outside the mask
    f_bit = 3;
    run(4'd0, 5'd8, 4'd8, -1, n, s0);
    chk("f3_fail", 32'(FAIL), 0);
    chk("f3_err", 32'(ERR_CNT), 0);

    // LEN=0 after a failing run: FAIL must be cleared, no access
    f_bit = 1;
    run(4'd0, 5'd8, 4'd8, -1, n, s0);
    chk("pre0_fail", 32'(FAIL), 1);
    run(4'd5, 5'd0, 4'd0, -1, n, s0);
    chk("len0_lat", 32'(n), 1);
    chk("len0_en0", 32'(en0), 0);
    chk("len0_nacc", 32'(nacc - s0), 0);
    chk("len0_fail", 32'(FAIL), 0);
    f_on0 = 1'b0;

    // START re-pulsed while busy is ignored
    run(4'd10, 5'd10, 4'd2, 5, n, s0);
    chk("rep_lat", 32'(n), 22);
    chk("rep_nacc", 32'(nacc - s0), 20);
    chk("rep_wa9", 32'(log_a[s0+9]), 3);
    chk("rep_ra0", 32'(log_a[s0+10]), 10);
    chk("rep_fail", 32'(FAIL), 0);

    // faults at 12 and 14 (bit 2, expected 4 and 6)
    f_bit = 2; f_a0 = 4'd12; f_a1 = 4'd14; f_on0 = 1'b1; f_on1 = 1'b1;
    run(4'd10, 5'd10, 4'd2, -1, n, s0);
    hit14 = 0;
    for (int i = s0; i < nacc; i++) if (!log_wr[i] && log_a[i] == 4'd14) hit14++;
    chk("two_fail", 32'(FAIL), 1);
    chk("two_faddr", 32'(FAIL_ADDR), 12);
`ifdef RAM_BIST_STOP_ON_ERR_EN
    chk("two_lat", 32'(n), 15);
    chk("two_err", 32'(ERR_CNT), 1);
    chk("two_rd14", 32'(hit14), 0);
    chk("two_nacc", 32'(nacc - s0), 14);
`else
    chk("two_lat", 32'(n), 22);
    chk("two_err", 32'(ERR_CNT), 2);
    chk("two_rd14", 32'(hit14), 1);
`endif
    f_on0 = 1'b0; f_on1 = 1'b0;

    // reset in the middle of READ
    BASE = 4'd10; LEN = 5'd10; SEED = 4'd2; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (12) @(negedge CLK);
    chk("mid_en", 32'(EN), 1);
    chk("mid_wr", 32'(WR), 0);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_en", 32'(EN), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_a", 32'(A), 0);
    chk("mid_rst_fail", 32'(FAIL), 0);
    chk("mid_rst_err", 32'(ERR_CNT), 0);
    s0 = nacc;
    @(negedge CLK);
    chk("mid_rst_noacc", 32'(nacc - s0), 0);
    RST = 1'b0;
    run(4'd10, 5'd10, 4'd2, -1, n, s0);
    chk("post_lat", 32'(n), 22);
    chk("post_fail", 32'(FAIL), 0);
    chk("post_nacc", 32'(nacc - s0), 20);
    @(negedge CLK);
    chk("post_done_clr", 32'(DONE), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
